// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART command-frame controller.
// Holds the FSM state encoding, frame byte codes and checksum helpers.
package uart_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CMD     = 4'd1,
        S_ADDR    = 4'd2,
        S_DATA    = 4'd3,
        S_CHK     = 4'd4,
        S_EXEC    = 4'd5,
        S_TX_HDR  = 4'd6,
        S_TX_STAT = 4'd7,
        S_TX_DATA = 4'd8,
        S_TX_CHK  = 4'd9
    } state_e;

    localparam logic [7:0] C_HDR_CMD = 8'hA5;
    localparam logic [7:0] C_HDR_RSP = 8'h5A;
    localparam logic [7:0] C_CMD_WR  = 8'h01;
    localparam logic [7:0] C_CMD_RD  = 8'h02;
    localparam logic [7:0] C_ST_OK   = 8'h00;
    localparam logic [7:0] C_ST_CHK  = 8'h01;
    localparam logic [7:0] C_ST_CMD  = 8'h02;

    function automatic logic cmd_chk_ok(input logic [7:0] cmd, input logic [7:0] addr,
                                        input logic [7:0] data, input logic [7:0] chk);
        return ((cmd ^ addr ^ data) == chk);
    endfunction

    function automatic logic [7:0] rsp_chk(input logic [7:0] stat, input logic [7:0] rdata);
        return (stat ^ rdata);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'h01);
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// raises a one-cycle expired pulse after P_TIMEOUT_CYC idle cycles (0 disables).
module uart_byte_timer #(
    parameter int P_TIMEOUT_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = (P_TIMEOUT_CYC > 1) ? $clog2(P_TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] C_LAST = CW'((P_TIMEOUT_CYC > 0) ? (P_TIMEOUT_CYC - 1) : 0);

    logic [CW-1:0] count_r;
    logic          expired_r;

    // Idle-cycle counter; restarts on every received byte or when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= {CW{1'b0}};
            expired_r <= 1'b0;
        end else if (clear || !en || (P_TIMEOUT_CYC == 0)) begin
            count_r   <= {CW{1'b0}};
            expired_r <= 1'b0;
        end else if (count_r == C_LAST) begin
            count_r   <= {CW{1'b0}};
            expired_r <= 1'b1;
        end else begin
            count_r   <= count_r + CW'(1);
            expired_r <= 1'b0;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame-level controller: parses 5-byte command frames from the UART RX byte
// stream, executes a register write/read and returns a 4-byte response frame.
module uart_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int P_TIMEOUT_CYC = 500000,
    parameter int P_ADDR_W      = 8
) (
    input  logic                I_clk,
    input  logic                I_rst_n,
    input  logic                I_rx_done,
    input  logic [7:0]          I_rx_data,
    output logic                O_tx_start,
    output logic [7:0]          O_tx_data,
    input  logic                I_tx_done,
    output logic                O_reg_wr_en,
    output logic [P_ADDR_W-1:0] O_reg_addr,
    output logic [7:0]          O_reg_wdata,
    input  logic [7:0]          I_reg_rdata,
    output logic                O_busy,
    output logic [7:0]          O_err_cnt
);

    state_e     state_r, state_nxt_s;
    logic [7:0] cmd_r, cmd_nxt_s;
    logic [7:0] addr_r, addr_nxt_s;
    logic [7:0] data_r, data_nxt_s;
    logic [7:0] chk_r, chk_nxt_s;
    logic [7:0] stat_r, stat_nxt_s;
    logic [7:0] rdata_r, rdata_nxt_s;
    logic [7:0] tx_data_r, tx_data_nxt_s;
    logic [7:0] err_cnt_r, err_nxt_s;
    logic       tx_start_r, tx_start_nxt_s;
    logic       wr_en_r, wr_en_nxt_s;
    logic       busy_r, busy_nxt_s;
    logic       rx_phase_s;
    logic       tmo_s;

    assign rx_phase_s = (state_r == S_CMD) || (state_r == S_ADDR) ||
                        (state_r == S_DATA) || (state_r == S_CHK);

    uart_byte_timer #(
        .P_TIMEOUT_CYC(P_TIMEOUT_CYC)
    ) u_byte_timer (
        .clk    (I_clk),
        .rst_n  (I_rst_n),
        .clear  (I_rx_done),
        .en     (rx_phase_s),
        .expired(tmo_s)
    );

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        cmd_nxt_s      = cmd_r;
        addr_nxt_s     = addr_r;
        data_nxt_s     = data_r;
        chk_nxt_s      = chk_r;
        stat_nxt_s     = stat_r;
        rdata_nxt_s    = rdata_r;
        tx_data_nxt_s  = tx_data_r;
        err_nxt_s      = err_cnt_r;
        busy_nxt_s     = busy_r;
        tx_start_nxt_s = 1'b0;
        wr_en_nxt_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (I_rx_done && (I_rx_data == C_HDR_CMD)) begin
                    state_nxt_s = S_CMD;
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CMD, S_ADDR, S_DATA, S_CHK: begin
                // A stalled frame is dropped without any response.
                if (tmo_s) begin
                    state_nxt_s = S_IDLE;
                    busy_nxt_s  = 1'b0;
                    err_nxt_s   = sat_inc8(err_cnt_r);
                end else if (I_rx_done) begin
                    case (state_r)
                        S_CMD:   begin cmd_nxt_s  = I_rx_data; state_nxt_s = S_ADDR; end
                        S_ADDR:  begin addr_nxt_s = I_rx_data; state_nxt_s = S_DATA; end
                        S_DATA:  begin data_nxt_s = I_rx_data; state_nxt_s = S_CHK;  end
                        S_CHK:   begin chk_nxt_s  = I_rx_data; state_nxt_s = S_EXEC; end
                        default: begin state_nxt_s = S_IDLE; end
                    endcase
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_EXEC: begin
                if (!cmd_chk_ok(cmd_r, addr_r, data_r, chk_r)) begin
                    stat_nxt_s  = C_ST_CHK;
                    rdata_nxt_s = 8'h00;
                    err_nxt_s   = sat_inc8(err_cnt_r);
                end else if (cmd_r == C_CMD_WR) begin
                    stat_nxt_s  = C_ST_OK;
                    rdata_nxt_s = data_r;
                    wr_en_nxt_s = 1'b1;
                end else if (cmd_r == C_CMD_RD) begin
                    stat_nxt_s  = C_ST_OK;
                    rdata_nxt_s = I_reg_rdata;
                end else begin
                    stat_nxt_s  = C_ST_CMD;
                    rdata_nxt_s = 8'h00;
                    err_nxt_s   = sat_inc8(err_cnt_r);
                end
                state_nxt_s    = S_TX_HDR;
                tx_start_nxt_s = 1'b1;
                tx_data_nxt_s  = C_HDR_RSP;
            end
            S_TX_HDR, S_TX_STAT, S_TX_DATA, S_TX_CHK: begin
                if (I_tx_done) begin
                    case (state_r)
                        S_TX_HDR: begin
                            state_nxt_s    = S_TX_STAT;
                            tx_start_nxt_s = 1'b1;
                            tx_data_nxt_s  = stat_r;
                        end
                        S_TX_STAT: begin
                            state_nxt_s    = S_TX_DATA;
                            tx_start_nxt_s = 1'b1;
                            tx_data_nxt_s  = rdata_r;
                        end
                        S_TX_DATA: begin
                            state_nxt_s    = S_TX_CHK;
                            tx_start_nxt_s = 1'b1;
                            tx_data_nxt_s  = rsp_chk(stat_r, rdata_r);
                        end
                        default: begin
                            state_nxt_s = S_IDLE;
                            busy_nxt_s  = 1'b0;
                        end
                    endcase
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_r    <= S_IDLE;
            cmd_r      <= 8'h00;
            addr_r     <= 8'h00;
            data_r     <= 8'h00;
            chk_r      <= 8'h00;
            stat_r     <= 8'h00;
            rdata_r    <= 8'h00;
            tx_data_r  <= 8'h00;
            err_cnt_r  <= 8'h00;
            busy_r     <= 1'b0;
            tx_start_r <= 1'b0;
            wr_en_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cmd_r      <= cmd_nxt_s;
            addr_r     <= addr_nxt_s;
            data_r     <= data_nxt_s;
            chk_r      <= chk_nxt_s;
            stat_r     <= stat_nxt_s;
            rdata_r    <= rdata_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            err_cnt_r  <= err_nxt_s;
            busy_r     <= busy_nxt_s;
            tx_start_r <= tx_start_nxt_s;
            wr_en_r    <= wr_en_nxt_s;
        end
    end

    assign O_tx_start  = tx_start_r;
    assign O_tx_data   = tx_data_r;
    assign O_reg_wr_en = wr_en_r;
    assign O_reg_addr  = addr_r[P_ADDR_W-1:0];
    assign O_reg_wdata = data_r;
    assign O_busy      = busy_r;
    assign O_err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: directed and randomized frames, expected
// response bytes and register writes queued by a frame-level reference model.
module tb_uart_cmd_ctrl;

    localparam int P_TMO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       wr_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       busy;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_tx_q[$];
    logic [15:0] exp_wr_q[$];
    logic [7:0]  model_regs [256];
    int          err_model = 0;

    logic [7:0]  bank [256];
    logic        bank_ready = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .P_TIMEOUT_CYC(P_TMO),
        .P_ADDR_W     (8)
    ) dut (
        .I_clk      (clk),
        .I_rst_n    (rst_n),
        .I_rx_done  (rx_done),
        .I_rx_data  (rx_data),
        .O_tx_start (tx_start),
        .O_tx_data  (tx_data),
        .I_tx_done  (tx_done),
        .O_reg_wr_en(wr_en),
        .O_reg_addr (reg_addr),
        .O_reg_wdata(reg_wdata),
        .I_reg_rdata(reg_rdata),
        .O_busy     (busy),
        .O_err_cnt  (err_cnt)
    );

    // Register bank seen by the DUT (environment, not the model).
    assign reg_rdata = bank[reg_addr];
    always @(posedge clk) begin
        if (!bank_ready) begin
            for (int i = 0; i < 256; i++) bank[i] <= 8'h00;
            bank_ready <= 1'b1;
        end else if (wr_en) begin
            bank[reg_addr] <= reg_wdata;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model: answers each tx_start with tx_done after a random delay.
    int tx_delay;
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && rst_n) begin
                tx_delay = $urandom_range(1, 5);
                repeat (tx_delay) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Monitor: pops expected TX bytes and register writes as the DUT presents them.
    logic       outstanding = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp_b;
    logic [15:0] exp_w;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                outstanding = 1'b0;
            end else begin
                if (tx_start) begin
                    check("tx_overlap", int'(outstanding), 0);
                    if (exp_tx_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got byte %0h expected none at %0t", tx_data, $time);
                        held = tx_data;
                    end else begin
                        exp_b = exp_tx_q.pop_front();
                        check("tx_byte", tx_data, exp_b);
                        held = exp_b;
                    end
                    outstanding = 1'b1;
                end else if (outstanding) begin
                    check("tx_hold", tx_data, held);
                    if (tx_done) outstanding = 1'b0;
                end
                if (wr_en) begin
                    if (exp_wr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL wr_unexpected: got %0h<=%0h expected none at %0t", reg_addr, reg_wdata, $time);
                    end else begin
                        exp_w = exp_wr_q.pop_front();
                        check("wr_addr_data", {reg_addr, reg_wdata}, exp_w);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        check("busy_drop", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero();
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_wdata", reg_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err_cnt", err_cnt, 0);
    endtask

    // Sends one command frame; reference model predicts response and write.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                             input logic [7:0] chk, input bit inject, input int gmin, input int gmax,
                             input bit abort);
        logic [7:0] stat;
        logic [7:0] rd;
        int starts;
        if ((cmd ^ addr ^ data) != chk) begin
            stat = 8'h01; rd = 8'h00;
            err_model = (err_model >= 255) ? 255 : err_model + 1;
        end else if (cmd == 8'h01) begin
            stat = 8'h00; rd = data;
            model_regs[addr] = data;
            exp_wr_q.push_back({addr, data});
        end else if (cmd == 8'h02) begin
            stat = 8'h00; rd = model_regs[addr];
        end else begin
            stat = 8'h02; rd = 8'h00;
            err_model = (err_model >= 255) ? 255 : err_model + 1;
        end
        exp_tx_q.push_back(8'h5A);
        exp_tx_q.push_back(stat);
        exp_tx_q.push_back(rd);
        exp_tx_q.push_back(stat ^ rd);

        send_byte(8'hA5, 0);
        @(negedge clk);
        check("busy_after_hdr", busy, 1);
        @(posedge clk); #1;
        send_byte(cmd, $urandom_range(gmin, gmax));
        send_byte(addr, $urandom_range(gmin, gmax));
        send_byte(data, $urandom_range(gmin, gmax));
        send_byte(chk, 0);
        @(negedge clk);
        check("lat_cycle1", tx_start, 0);
        @(negedge clk);
        check("lat_cycle2", tx_start, 1);
        if (abort) begin
            starts = 1;
            for (int i = 0; i < 200 && starts < 3; i++) begin
                @(negedge clk);
                if (tx_start) starts++;
            end
            check("abort_reach_tx_data", starts, 3);
            #1 rst_n = 1'b0;
            exp_tx_q.delete();
            err_model = 0;
            @(negedge clk);
            check_all_zero();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (10) @(posedge clk);
            #1;
        end else begin
            if (inject) begin
                @(posedge clk); #1;
                send_byte(8'hA5, 0);
                send_byte(8'h01, 0);
                send_byte(8'h10, 0);
            end
            wait_idle();
        end
        check("err_cnt", err_cnt, err_model);
        check("tx_queue_drained", exp_tx_q.size(), 0);
        check("wr_queue_drained", exp_wr_q.size(), 0);
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] r_cmd, r_addr, r_data, r_chk, g;
    initial begin
        for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_frame(8'h01, 8'h10, 8'h3C, 8'h2D, 1'b0, 0, 2, 1'b0);
        run_frame(8'h02, 8'h10, 8'h00, 8'h12, 1'b1, 0, 2, 1'b0);
        run_frame(8'h01, 8'h10, 8'h3C, 8'h00, 1'b0, 0, 2, 1'b0);
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        @(negedge clk);
        check("garbage_no_busy", busy, 0);
        check("garbage_no_err", err_cnt, err_model);
        @(posedge clk); #1;
        run_frame(8'h07, 8'h00, 8'h00, 8'h07, 1'b0, 0, 2, 1'b0);

        // Inter-byte timeout: header and command then silence.
        err_model = err_model + 1;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        repeat (150) @(negedge clk);
        check("tmo_busy", busy, 0);
        check("tmo_err_cnt", err_cnt, err_model);
        check("tmo_no_tx", exp_tx_q.size(), 0);
        @(posedge clk); #1;

        // Gaps just below the timeout keep the frame alive.
        run_frame(8'h01, 8'h22, 8'h5E, 8'h01 ^ 8'h22 ^ 8'h5E, 1'b0, 90, 90, 1'b0);

        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: r_cmd = 8'h01;
                4, 5, 6, 7: r_cmd = 8'h02;
                default:    r_cmd = 8'($urandom);
            endcase
            r_addr = 8'($urandom_range(0, 7));
            r_data = 8'($urandom);
            r_chk  = r_cmd ^ r_addr ^ r_data;
            if ($urandom_range(0, 4) == 0) r_chk = r_chk ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 2) == 0) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, 1);
            end
            run_frame(r_cmd, r_addr, r_data, r_chk, 1'($urandom_range(0, 1)), 0, 3, 1'b0);
        end

        // Reset in the middle of the response, then confirm recovery.
        run_frame(8'h01, 8'h20, 8'h55, 8'h74, 1'b0, 0, 1, 1'b1);
        run_frame(8'h02, 8'h20, 8'h00, 8'h22, 1'b1, 0, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
